// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD timing generator: free-running h/v counters, a fetch stage running
// LEAD pixels ahead of display, and a LEAD-deep pipeline that re-aligns sync and coordinates to de.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 40,
    parameter int H_SYNC     = 88,
    parameter int H_BACK     = 47,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 13,
    parameter int V_SYNC     = 3,
    parameter int V_BACK     = 31,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int LEAD       = 2,
    parameter int SCALE      = 0,
    parameter int CNT_W      = 11,
    parameter int ADDR_W     = 19
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              pix_ce,
    output logic              fetch_valid,
    output logic [CNT_W-1:0]  fetch_x,
    output logic [CNT_W-1:0]  fetch_y,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              de,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    output logic              hsync,
    output logic              vsync,
    output logic              line_start,
    output logic              frame_start,
    output logic [15:0]       frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0]  H_VIS_C      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0]  V_VIS_C      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0]  H_VIS_LAST_C = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0]  V_VIS_LAST_C = CNT_W'(V_VISIBLE - 1);
    localparam logic [CNT_W-1:0]  H_LAST_C     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST_C     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  HS_START_C   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0]  HS_END_C     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0]  VS_START_C   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0]  VS_END_C     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0]  REP_MASK_C   = CNT_W'((1 << SCALE) - 1);
    localparam logic [ADDR_W-1:0] SRC_W_C      = ADDR_W'(H_VISIBLE >> SCALE);
    localparam logic              H_POL        = (H_SYNC_POL != 0);
    localparam logic              V_POL        = (V_SYNC_POL != 0);

    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]  v_cnt_q, v_cnt_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [CNT_W-1:0]  fetch_x_q, fetch_x_d;
    logic [CNT_W-1:0]  fetch_y_q, fetch_y_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic [LEAD-1:0]            pipe_valid_q, pipe_valid_d;
    logic [LEAD-1:0][CNT_W-1:0] pipe_x_q, pipe_x_d;
    logic [LEAD-1:0][CNT_W-1:0] pipe_y_q, pipe_y_d;
    logic [LEAD-1:0]            pipe_hs_q, pipe_hs_d;
    logic [LEAD-1:0]            pipe_vs_q, pipe_vs_d;

    logic h_last, v_last, visible;

    always_comb begin
        h_last  = (h_cnt_q == H_LAST_C);
        v_last  = (v_cnt_q == V_LAST_C);
        visible = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);

        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        line_base_d   = line_base_q;
        fetch_valid_d = fetch_valid_q;
        fetch_x_d     = fetch_x_q;
        fetch_y_d     = fetch_y_q;
        fetch_addr_d  = fetch_addr_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        pipe_valid_d  = pipe_valid_q;
        pipe_x_d      = pipe_x_q;
        pipe_y_d      = pipe_y_q;
        pipe_hs_d     = pipe_hs_q;
        pipe_vs_d     = pipe_vs_q;

        if (pix_ce) begin
            h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
            if (h_last) begin
                v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
            end

            fetch_valid_d = visible;
            if (visible) begin
                fetch_x_d    = h_cnt_q;
                fetch_y_d    = v_cnt_q;
                fetch_addr_d = line_base_q + ADDR_W'(h_cnt_q >> SCALE);
            end
            hs_d = (h_cnt_q >= HS_START_C) && (h_cnt_q < HS_END_C);
            vs_d = (v_cnt_q >= VS_START_C) && (v_cnt_q < VS_END_C);

            line_start_d  = visible && (h_cnt_q == '0);
            frame_start_d = line_start_d && (v_cnt_q == '0);
            if (frame_start_d) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end

            // Advance the source row only after the last replicated copy of a line.
            if (visible && (h_cnt_q == H_VIS_LAST_C)) begin
                if (v_cnt_q == V_VIS_LAST_C) begin
                    line_base_d = '0;
                end else if ((v_cnt_q & REP_MASK_C) == REP_MASK_C) begin
                    line_base_d = line_base_q + SRC_W_C;
                end
            end

            pipe_valid_d[0] = fetch_valid_q;
            pipe_x_d[0]     = fetch_x_q;
            pipe_y_d[0]     = fetch_y_q;
            pipe_hs_d[0]    = hs_q;
            pipe_vs_d[0]    = vs_q;
            for (int i = 1; i < LEAD; i++) begin
                pipe_valid_d[i] = pipe_valid_q[i-1];
                pipe_x_d[i]     = pipe_x_q[i-1];
                pipe_y_d[i]     = pipe_y_q[i-1];
                pipe_hs_d[i]    = pipe_hs_q[i-1];
                pipe_vs_d[i]    = pipe_vs_q[i-1];
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_base_q   <= '0;
            fetch_valid_q <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
            fetch_addr_q  <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            pipe_valid_q  <= '0;
            pipe_x_q      <= '0;
            pipe_y_q      <= '0;
            pipe_hs_q     <= '0;
            pipe_vs_q     <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_base_q   <= line_base_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
            fetch_addr_q  <= fetch_addr_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            pipe_valid_q  <= pipe_valid_d;
            pipe_x_q      <= pipe_x_d;
            pipe_y_q      <= pipe_y_d;
            pipe_hs_q     <= pipe_hs_d;
            pipe_vs_q     <= pipe_vs_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_x     = fetch_x_q;
    assign fetch_y     = fetch_y_q;
    assign fetch_addr  = fetch_addr_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign de          = pipe_valid_q[LEAD-1];
    assign pix_x       = pipe_x_q[LEAD-1];
    assign pix_y       = pipe_y_q[LEAD-1];
    // Pipeline carries raw "sync active"; polarity is applied only at the pins.
    assign hsync       = H_POL ? pipe_hs_q[LEAD-1] : ~pipe_hs_q[LEAD-1];
    assign vsync       = V_POL ? pipe_vs_q[LEAD-1] : ~pipe_vs_q[LEAD-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x7 timing set: a positive-polarity SCALE=0 instance,
// a SCALE=1 instance and a negative-polarity instance share clock, reset and pix_ce.
module tb_vga_timing_gen;

    localparam int H_VIS = 8;
    localparam int H_TOT = 14;
    localparam int V_VIS = 4;
    localparam int V_TOT = 7;
    localparam int FRAME = H_TOT * V_TOT;

    logic vga_clk = 1'b0;
    logic reset;
    logic pix_ce;

    logic        fetch_valid, de, hsync, vsync, line_start, frame_start;
    logic [10:0] fetch_x, fetch_y, pix_x, pix_y;
    logic [18:0] fetch_addr;
    logic [15:0] frame_cnt;

    logic        s1_fetch_valid, s1_de, s1_hsync, s1_vsync, s1_line_start, s1_frame_start;
    logic [10:0] s1_fetch_x, s1_fetch_y, s1_pix_x, s1_pix_y;
    logic [18:0] s1_fetch_addr;
    logic [15:0] s1_frame_cnt;

    logic        np_fetch_valid, np_de, np_hsync, np_vsync, np_line_start, np_frame_start;
    logic [10:0] np_fetch_x, np_fetch_y, np_pix_x, np_pix_y;
    logic [18:0] np_fetch_addr;
    logic [15:0] np_frame_cnt;

    int checks   = 0;
    int failures = 0;
    int cur_k    = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .LEAD(2), .SCALE(0), .CNT_W(11), .ADDR_W(19)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
        .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_addr(fetch_addr),
        .de(de), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .LEAD(2), .SCALE(1), .CNT_W(11), .ADDR_W(19)
    ) dut_s1 (
        .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
        .fetch_valid(s1_fetch_valid), .fetch_x(s1_fetch_x), .fetch_y(s1_fetch_y),
        .fetch_addr(s1_fetch_addr), .de(s1_de), .pix_x(s1_pix_x), .pix_y(s1_pix_y),
        .hsync(s1_hsync), .vsync(s1_vsync), .line_start(s1_line_start),
        .frame_start(s1_frame_start), .frame_cnt(s1_frame_cnt)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .LEAD(2), .SCALE(0), .CNT_W(11), .ADDR_W(19)
    ) dut_np (
        .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
        .fetch_valid(np_fetch_valid), .fetch_x(np_fetch_x), .fetch_y(np_fetch_y),
        .fetch_addr(np_fetch_addr), .de(np_de), .pix_x(np_pix_x), .pix_y(np_pix_y),
        .hsync(np_hsync), .vsync(np_vsync), .line_start(np_line_start),
        .frame_start(np_frame_start), .frame_cnt(np_frame_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s k=%0d obs=%0d exp=%0d", tag, cur_k, obs, exp);
        end
    endtask

    // k = pix_ce edges since reset release; fetch shows counter position k-1,
    // display shows position k-3 (LEAD=2). Positions before 0 mean reset values.
    task automatic check_all(input int k, input bit ce_last);
        int p, h, v, fx, fy, d, hd, vd, dx, dy, fr;
        bit vis, ls, fs, dvis, hs, vs;
        cur_k = k;
        if (k == 0) begin
            vis = 0; fx = 0; fy = 0; ls = 0; fs = 0; fr = 0;
        end else begin
            p   = k - 1;
            h   = p % H_TOT;
            v   = (p / H_TOT) % V_TOT;
            vis = (h < H_VIS) && (v < V_VIS);
            fx  = vis ? h : H_VIS - 1;
            fy  = (v < V_VIS) ? v : V_VIS - 1;
            ls  = ce_last && vis && (h == 0);
            fs  = ls && (v == 0);
            fr  = p / FRAME + 1;
        end
        d = k - 3;
        if (d < 0) begin
            dvis = 0; dx = 0; dy = 0; hs = 0; vs = 0;
        end else begin
            hd   = d % H_TOT;
            vd   = (d / H_TOT) % V_TOT;
            dvis = (hd < H_VIS) && (vd < V_VIS);
            dx   = dvis ? hd : H_VIS - 1;
            dy   = (vd < V_VIS) ? vd : V_VIS - 1;
            hs   = (hd >= 10) && (hd < 12);
            vs   = (vd == 5);
        end
        check_eq("fetch_valid", 32'(fetch_valid), 32'(vis));
        check_eq("fetch_x", 32'(fetch_x), 32'(fx));
        check_eq("fetch_y", 32'(fetch_y), 32'(fy));
        check_eq("fetch_addr", 32'(fetch_addr), 32'(fy * 8 + fx));
        check_eq("line_start", 32'(line_start), 32'(ls));
        check_eq("frame_start", 32'(frame_start), 32'(fs));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(fr));
        check_eq("de", 32'(de), 32'(dvis));
        check_eq("pix_x", 32'(pix_x), 32'(dx));
        check_eq("pix_y", 32'(pix_y), 32'(dy));
        check_eq("hsync", 32'(hsync), 32'(hs));
        check_eq("vsync", 32'(vsync), 32'(vs));
        check_eq("s1_fetch_addr", 32'(s1_fetch_addr), 32'((fy / 2) * 4 + fx / 2));
        check_eq("s1_de", 32'(s1_de), 32'(dvis));
        check_eq("np_hsync", 32'(np_hsync), 32'(!hs));
        check_eq("np_vsync", 32'(np_vsync), 32'(!vs));
        check_eq("np_de", 32'(np_de), 32'(dvis));
    endtask

    initial begin
        int k;
        bit ce;
        reset  = 1'b1;
        pix_ce = 1'b0;
        repeat (2) @(negedge vga_clk);
        check_all(0, 1'b0);

        // Continuous pix_ce: two full frames plus up to row 2, x 5 of the third.
        reset  = 1'b0;
        pix_ce = 1'b1;
        for (int i = 1; i <= 2 * FRAME + 34; i++) begin
            @(negedge vga_clk);
            check_all(i, 1'b1);
        end
        check_eq("mid_x", 32'(fetch_x), 32'd5);
        check_eq("mid_y", 32'(fetch_y), 32'd2);
        check_eq("mid_frame_cnt", 32'(frame_cnt), 32'd3);

        // Asynchronous reset away from the clock edge must clear outputs at once.
        reset = 1'b1;
        #1;
        check_all(0, 1'b0);
        @(negedge vga_clk);
        check_all(0, 1'b0);
        reset = 1'b0;

        // pix_ce toggling 1,0,1,0: state advances on every other clock only.
        k = 0;
        for (int i = 0; i < 80; i++) begin
            ce     = (i % 2 == 0);
            pix_ce = ce;
            @(negedge vga_clk);
            if (ce) k++;
            check_all(k, ce);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
